// File: rtl/fetch_queue_if.sv
// Fetch-to-dispatch bundle for fetch_queue: two fetched instructions in,
// two oldest instructions out, plus flush/stall handshakes and occupancy.
interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic [31:0]   inst1_in;
    logic [31:0]   inst2_in;
    logic          inst1_in_valid;
    logic          inst2_in_valid;
    logic [63:0]   pc_in;
    logic          dispatch_stall;

    logic          fq_stall;
    logic [31:0]   inst1_out;
    logic [31:0]   inst2_out;
    logic [63:0]   inst1_pc_out;
    logic [63:0]   inst2_pc_out;
    logic          inst1_out_valid;
    logic          inst2_out_valid;
    logic [CW-1:0] count;

    // Fetch/dispatch side: drives instructions and stalls, observes the queue.
    modport master (
        output flush, inst1_in, inst2_in, inst1_in_valid, inst2_in_valid,
               pc_in, dispatch_stall,
        input  fq_stall, inst1_out, inst2_out, inst1_pc_out, inst2_pc_out,
               inst1_out_valid, inst2_out_valid, count
    );

    // Queue side.
    modport slave (
        input  flush, inst1_in, inst2_in, inst1_in_valid, inst2_in_valid,
               pc_in, dispatch_stall,
        output fq_stall, inst1_out, inst2_out, inst1_pc_out, inst2_pc_out,
               inst1_out_valid, inst2_out_valid, count
    );
endinterface

// File: rtl/fetch_queue.sv
// 2-in/2-out circular instruction buffer between fetch and dispatch, with
// show-ahead outputs, fetch back-pressure and full squash on a taken branch.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    fetch_queue_if.slave fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          enq_ok;
    logic          deq_ok;
    logic          out1_valid;
    logic          out2_valid;
    logic [1:0]    nenq;
    logic [1:0]    ndeq;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] inst2_slot;

    // Stall is purely a function of registered occupancy, so it never glitches.
    assign fq.fq_stall = (count > CW'(DEPTH - 2));
    assign fq.count    = count;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        enq_ok     = !fq.fq_stall && !fq.flush;
        deq_ok     = !fq.dispatch_stall && !fq.flush;
        nenq       = enq_ok ? ({1'b0, fq.inst1_in_valid} + {1'b0, fq.inst2_in_valid}) : 2'd0;
        inst2_slot = fq.inst1_in_valid ? tail + PW'(1) : tail;
        head_p1    = head + PW'(1);

        out1_valid = (count >= CW'(1)) && !fq.flush;
        out2_valid = (count >= CW'(2)) && !fq.flush;
        ndeq       = deq_ok ? ({1'b0, out1_valid} + {1'b0, out2_valid}) : 2'd0;

        fq.inst1_out_valid = out1_valid;
        fq.inst2_out_valid = out2_valid;
        fq.inst1_out       = '0;
        fq.inst1_pc_out    = '0;
        fq.inst2_out       = '0;
        fq.inst2_pc_out    = '0;
        if (out1_valid) begin
            fq.inst1_out    = mem[head].inst;
            fq.inst1_pc_out = mem[head].pc;
        end
        if (out2_valid) begin
            fq.inst2_out    = mem[head_p1].inst;
            fq.inst2_pc_out = mem[head_p1].pc;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clock) begin
        if (enq_ok) begin
            if (fq.inst1_in_valid) mem[tail]       <= '{inst: fq.inst1_in, pc: fq.pc_in};
            if (fq.inst2_in_valid) mem[inst2_slot] <= '{inst: fq.inst2_in, pc: fq.pc_in + 64'd4};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset || fq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(ndeq);
            tail  <= tail + PW'(nenq);
            count <= count + CW'(nenq) - CW'(ndeq);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random-traffic bench for fetch_queue, checked against a
// queue-based scoreboard of expected {inst, pc} entries.
module tb_fetch_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_asserts = 0;
    int   n_fail = 0;
    ent_t sb[$];
    logic [63:0] rpc;

    fetch_queue_if #(.DEPTH(DEPTH)) fq_bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .fq    (fq_bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic [31:0] i1, input logic v2,
                         input logic [31:0] i2, input logic [63:0] pc,
                         input logic ds, input logic fl, input logic rst);
        fq_bus.inst1_in_valid = v1;
        fq_bus.inst1_in       = i1;
        fq_bus.inst2_in_valid = v2;
        fq_bus.inst2_in       = i2;
        fq_bus.pc_in          = pc;
        fq_bus.dispatch_stall = ds;
        fq_bus.flush          = fl;
        reset                 = rst;
    endtask

    // Compare all outputs against the scoreboard head for the current cycle.
    task automatic check_outputs();
        logic e1, e2;
        int   n;
        n  = sb.size();
        e1 = (n >= 1) && !fq_bus.flush;
        e2 = (n >= 2) && !fq_bus.flush;
        check("count", 64'(fq_bus.count), 64'(n));
        check("fq_stall", 64'(fq_bus.fq_stall), 64'((DEPTH - n) < 2));
        check("inst1_out_valid", 64'(fq_bus.inst1_out_valid), 64'(e1));
        check("inst2_out_valid", 64'(fq_bus.inst2_out_valid), 64'(e2));
        check("inst1_out", 64'(fq_bus.inst1_out), e1 ? 64'(sb[0].inst) : 64'd0);
        check("inst1_pc_out", fq_bus.inst1_pc_out, e1 ? sb[0].pc : 64'd0);
        check("inst2_out", 64'(fq_bus.inst2_out), e2 ? 64'(sb[1].inst) : 64'd0);
        check("inst2_pc_out", fq_bus.inst2_pc_out, e2 ? sb[1].pc : 64'd0);
    endtask

    // Scoreboard update for the coming edge, from the stimulus currently driven.
    task automatic model_edge();
        int   ndeq;
        logic stall;
        if (!reset || fq_bus.flush) begin
            sb.delete();
        end else begin
            stall = (DEPTH - sb.size()) < 2;
            ndeq  = fq_bus.dispatch_stall ? 0 : ((sb.size() >= 2) ? 2 : sb.size());
            repeat (ndeq) void'(sb.pop_front());
            if (!stall) begin
                if (fq_bus.inst1_in_valid) sb.push_back('{fq_bus.inst1_in, fq_bus.pc_in});
                if (fq_bus.inst2_in_valid) sb.push_back('{fq_bus.inst2_in, fq_bus.pc_in + 64'd4});
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check_outputs();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic v1, input logic [31:0] i1, input logic v2,
                        input logic [31:0] i2, input logic [63:0] pc,
                        input logic ds, input logic fl, input logic rst);
        drive(v1, i1, v2, i2, pc, ds, fl, rst);
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        sb.delete();

        // Reset release: empty queue, everything zero.
        reset = 1'b1;
        #1;
        check("rst_count", 64'(fq_bus.count), 64'd0);
        check("rst_stall", 64'(fq_bus.fq_stall), 64'd0);
        check("rst_v1", 64'(fq_bus.inst1_out_valid), 64'd0);
        check("rst_pc1", fq_bus.inst1_pc_out, 64'd0);
        step(0, 0, 0, 0, 0, 1, 0, 1);

        // First pair, visible one cycle later.
        step(1, 32'h56783456, 1, 32'h12344567, 64'h0, 1, 0, 1);
        check("first_count", 64'(fq_bus.count), 64'd2);
        check("first_inst1", 64'(fq_bus.inst1_out), 64'h56783456);
        check("first_pc1", fq_bus.inst1_pc_out, 64'h0);
        check("first_inst2", 64'(fq_bus.inst2_out), 64'h12344567);
        check("first_pc2", fq_bus.inst2_pc_out, 64'h4);

        // Fill to DEPTH, then one more pair must be dropped.
        for (int k = 1; k < 4; k++)
            step(1, 32'hA000 + 32'(k), 1, 32'hB000 + 32'(k), 64'(8 * k), 1, 0, 1);
        check("full_count", 64'(fq_bus.count), 64'd8);
        check("full_stall", 64'(fq_bus.fq_stall), 64'd1);
        step(1, 32'hDEAD, 1, 32'hBEEF, 64'h20, 1, 0, 1);
        check("full_drop_count", 64'(fq_bus.count), 64'd8);

        // Drain two per cycle, oldest first.
        for (int k = 0; k < 4; k++) begin
            check("drain_count", 64'(fq_bus.count), 64'(8 - 2 * k));
            check("drain_pc1", fq_bus.inst1_pc_out, 64'(8 * k));
            check("drain_pc2", fq_bus.inst2_pc_out, 64'(8 * k + 4));
            step(0, 0, 0, 0, 0, 0, 0, 1);
        end
        check("drained_count", 64'(fq_bus.count), 64'd0);
        check("drained_v1", 64'(fq_bus.inst1_out_valid), 64'd0);

        // Only inst2 valid: compacted into the oldest slot with pc+4.
        step(0, 0, 1, 32'h7777, 64'h100, 1, 0, 1);
        check("solo_v1", 64'(fq_bus.inst1_out_valid), 64'd1);
        check("solo_pc1", fq_bus.inst1_pc_out, 64'h104);
        check("solo_v2", 64'(fq_bus.inst2_out_valid), 64'd0);

        // Reach DEPTH-1: stall even for a single instruction.
        for (int k = 0; k < 3; k++)
            step(1, 32'hC000 + 32'(k), 1, 32'hD000 + 32'(k), 64'h200 + 64'(8 * k), 1, 0, 1);
        check("seven_count", 64'(fq_bus.count), 64'd7);
        check("seven_stall", 64'(fq_bus.fq_stall), 64'd1);
        step(1, 32'h1111, 0, 0, 64'h300, 1, 0, 1);
        check("seven_drop", 64'(fq_bus.count), 64'd7);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("five_count", 64'(fq_bus.count), 64'd5);

        // Flush with a valid pair and dispatch ready.
        drive(1, 32'h2222, 1, 32'h3333, 64'h400, 0, 1, 1);
        #1;
        check("flush_v1", 64'(fq_bus.inst1_out_valid), 64'd0);
        check("flush_v2", 64'(fq_bus.inst2_out_valid), 64'd0);
        tick();
        check("post_flush_count", 64'(fq_bus.count), 64'd0);
        step(1, 32'h4444, 1, 32'h5555, 64'h100, 1, 0, 1);
        check("post_flush_pc1", fq_bus.inst1_pc_out, 64'h100);
        check("post_flush_inst1", 64'(fq_bus.inst1_out), 64'h4444);

        // Reset wins over flush, enqueue and dequeue.
        step(1, 32'h6666, 1, 32'h7777, 64'h500, 0, 1, 0);
        check("mid_reset_count", 64'(fq_bus.count), 64'd0);
        step(1, 32'h6666, 1, 32'h7777, 64'h500, 0, 0, 0);
        check("mid_reset_count2", 64'(fq_bus.count), 64'd0);

        // Random traffic exercises wrap-around and mixed enqueue/dequeue.
        rpc = 64'h1000;
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, rpc,
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 4),
                 !($urandom_range(0, 99) < 2));
            rpc = rpc + 64'd8;
        end
        step(0, 0, 0, 0, 0, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
